// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit WISC core: opcodes, default widths and reset vector.
package wisc_pkg;

  localparam int unsigned WISC_ADDR_W  = 16;
  localparam int unsigned WISC_INSTR_W = 16;

  localparam logic [WISC_ADDR_W-1:0] WISC_RESET_VECTOR = 16'h0000;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

endpackage

// File: rtl/fetch_fifo.sv
// First-word fall-through queue of fetched {pc, instr} entries with push, pop and flush.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop, wr_en;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_push = push && (count_q != CNT_W'(DEPTH));
    do_pop  = pop && (count_q != '0);
    wr_en   = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      wr_en = do_push;
      if (do_push) tail_d = tail_q + PTR_W'(1);
      if (do_pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; consumers only look at it while valid is high.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail_q] <= push_data;
  end

  assign head_data = mem_q[head_q];
  assign valid     = (count_q != '0);
  assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// WISC fetch front end: owns the fetch PC, keeps one request in flight, and feeds decode from a prefetch queue.
module fetch_queue
  import wisc_pkg::*;
#(
  parameter int unsigned      ADDR_W     = WISC_ADDR_W,
  parameter int unsigned      INSTR_W    = WISC_INSTR_W,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(WISC_RESET_VECTOR),
  parameter logic [3:0]       HLT_OPCODE = OP_HLT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus2,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               hlt
);

  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d, req_addr_q, req_addr_d;
  logic               outstanding_q, outstanding_d, drop_q, drop_d;
  logic               fetch_halted_q, fetch_halted_d, hlt_q, hlt_d, run_q, run_d;
  logic               redir, rsp, accept, rsp_halt, issue, pop;
  logic [ENTRY_W-1:0] head;
  logic               fifo_valid;
  logic [CNT_W-1:0]   fifo_count;

  always_comb begin
    redir    = redirect_valid && !hlt_q;
    rsp      = imem_rvalid && outstanding_q;
    accept   = rsp && !drop_q && !redir;
    // An HLT landing this cycle must already block the next issue.
    rsp_halt = accept && (imem_rdata[INSTR_W-1 -: 4] == HLT_OPCODE);
    issue    = run_q && !fetch_halted_q && !rsp_halt && !hlt_q && !redirect_valid &&
               (!outstanding_q || imem_rvalid) &&
               (int'(fifo_count) + int'(outstanding_q) < int'(DEPTH));
    pop      = fifo_valid && id_ready;

    run_d          = 1'b1;
    fetch_pc_d     = fetch_pc_q;
    req_addr_d     = req_addr_q;
    outstanding_d  = outstanding_q;
    drop_d         = drop_q;
    fetch_halted_d = fetch_halted_q;
    hlt_d          = hlt_q || (pop && (head[INSTR_W-1 -: 4] == HLT_OPCODE));

    if (issue) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(2);
      req_addr_d    = fetch_pc_q;
      outstanding_d = 1'b1;
    end else if (rsp) begin
      outstanding_d = 1'b0;
    end

    if (redir) begin
      fetch_pc_d     = redirect_pc & ~ADDR_W'(1);
      fetch_halted_d = 1'b0;
      drop_d         = outstanding_q && !imem_rvalid;
    end else begin
      if (rsp)      drop_d         = 1'b0;
      if (rsp_halt) fetch_halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q          <= 1'b0;
      fetch_pc_q     <= RESET_PC;
      req_addr_q     <= RESET_PC;
      outstanding_q  <= 1'b0;
      drop_q         <= 1'b0;
      fetch_halted_q <= 1'b0;
      hlt_q          <= 1'b0;
    end else begin
      run_q          <= run_d;
      fetch_pc_q     <= fetch_pc_d;
      req_addr_q     <= req_addr_d;
      outstanding_q  <= outstanding_d;
      drop_q         <= drop_d;
      fetch_halted_q <= fetch_halted_d;
      hlt_q          <= hlt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redir),
    .push      (accept),
    .push_data ({req_addr_q, imem_rdata}),
    .pop       (pop),
    .head_data (head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc_q;
  assign pc          = fetch_pc_q;
  assign hlt         = hlt_q;
  assign id_valid    = fifo_valid;
  assign id_instr    = fifo_valid ? head[INSTR_W-1:0] : '0;
  assign id_pc       = fifo_valid ? head[ENTRY_W-1 -: ADDR_W] : '0;
  assign id_pc_plus2 = id_pc + ADDR_W'(2);

endmodule
